fsm_vedacao_rolhas: RTL and testbench

Slave FSM for the sealing (vedação) station. It answers the master sequencer's `cmd_vedar` command by driving the capping actuator for a fixed time, then returning `vedacao_concluida`. It also owns the cork (rolha) inventory: it decrements stock per sealed bottle, accepts refills from an operator key, and raises `alarme_rolha` that the master uses to halt the line.

---
 rtl/fsm_vedacao_rolhas.sv | 101 ++++++++++
 tb/tb_fsm_vedacao_rolhas.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_vedacao_rolhas.sv
// rtl/fsm_vedacao_rolhas.sv - sealing station slave FSM with cork inventory
// Drives the capping actuator for a fixed time per command and tracks cork stock.
module fsm_vedacao_rolhas #(
   parameter int TEMPO_VEDACAO   = 100,
   parameter int ESTOQUE_INICIAL = 20,
   parameter int ESTOQUE_MAX     = 99,
   parameter int REPOSICAO_QTD   = 15,
   parameter int LIMIAR_BAIXO    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_vedar,
   input  logic       reposicao,
   output logic       atuador_vedacao,
   output logic       vedacao_concluida,
   output logic       alarme_rolha,
   output logic       rolha_baixa,
   output logic [6:0] estoque_rolhas
);

   localparam int TW = (TEMPO_VEDACAO > 1) ? $clog2(TEMPO_VEDACAO) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      VEDANDO   = 2'd1,
      CONCLUIDO = 2'd2,
      SEM_ROLHA = 2'd3
   } estado_t;

   estado_t        state, state_next;
   logic [TW-1:0]  timer, timer_next;
   logic [6:0]     estoque, estoque_next;
   logic           reposicao_prev;
   logic           decremento;
   logic           incremento;
   logic [7:0]     soma;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         timer          <= '0;
         estoque        <= 7'(ESTOQUE_INICIAL);
         reposicao_prev <= 1'b0;
      end else begin
         state          <= state_next;
         timer          <= timer_next;
         estoque        <= estoque_next;
         reposicao_prev <= reposicao;
      end
   end

   // An abort from the master takes priority over completion, so no cork is consumed.
   always_comb begin
      state_next = state;
      timer_next = timer;
      decremento = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_vedar) begin
               if (estoque != 7'd0) begin
                  state_next = VEDANDO;
                  timer_next = '0;
               end else begin
                  state_next = SEM_ROLHA;
               end
            end
         end
         VEDANDO: begin
            if (!cmd_vedar) begin
               state_next = IDLE;
               timer_next = '0;
            end else if (timer == TW'(TEMPO_VEDACAO - 1)) begin
               state_next = CONCLUIDO;
               decremento = 1'b1;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         CONCLUIDO: begin
            if (!cmd_vedar) state_next = IDLE;
         end
         SEM_ROLHA: begin
            if (estoque != 7'd0 || !cmd_vedar) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // 8-bit sum so decrement plus refill never wraps before saturation.
   assign incremento   = reposicao & ~reposicao_prev;
   assign soma         = {1'b0, estoque} - {7'd0, decremento}
                         + (incremento ? 8'(REPOSICAO_QTD) : 8'd0);
   assign estoque_next = (soma > 8'(ESTOQUE_MAX)) ? 7'(ESTOQUE_MAX) : soma[6:0];

   assign atuador_vedacao   = (state == VEDANDO);
   assign vedacao_concluida = (state == CONCLUIDO);
   assign alarme_rolha      = (estoque == 7'd0) && (state != CONCLUIDO);
   assign rolha_baixa       = (estoque != 7'd0) && (estoque <= 7'(LIMIAR_BAIXO));
   assign estoque_rolhas    = estoque;

endmodule

// File: tb/tb_fsm_vedacao_rolhas.sv
// tb/tb_fsm_vedacao_rolhas.sv - self-checking bench for fsm_vedacao_rolhas
// Directed plan followed by randomized master/operator activity against a cycle model.
module tb_fsm_vedacao_rolhas;

   localparam int T    = 4;
   localparam int INIT = 2;
   localparam int MAXS = 6;
   localparam int QTD  = 5;
   localparam int LIM  = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_vedar = 1'b0;
   logic       reposicao = 1'b0;
   logic       atuador_vedacao;
   logic       vedacao_concluida;
   logic       alarme_rolha;
   logic       rolha_baixa;
   logic [6:0] estoque_rolhas;

   int checks = 0;
   int errors = 0;

   // Model: remaining actuator cycles, done handshake pending, blocked for lack of corks.
   int m_rem, m_stock;
   bit m_done, m_blocked, m_prev;

   fsm_vedacao_rolhas #(
      .TEMPO_VEDACAO(T), .ESTOQUE_INICIAL(INIT), .ESTOQUE_MAX(MAXS),
      .REPOSICAO_QTD(QTD), .LIMIAR_BAIXO(LIM)
   ) dut (
      .clk(clk), .reset(reset), .cmd_vedar(cmd_vedar), .reposicao(reposicao),
      .atuador_vedacao(atuador_vedacao), .vedacao_concluida(vedacao_concluida),
      .alarme_rolha(alarme_rolha), .rolha_baixa(rolha_baixa),
      .estoque_rolhas(estoque_rolhas)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rem = 0; m_done = 0; m_blocked = 0; m_prev = 0; m_stock = INIT;
   endtask

   task automatic model_edge(input bit c, input bit r);
      int dec, add;
      dec = 0;
      add = (r && !m_prev) ? QTD : 0;
      if (m_rem > 0) begin
         if (!c) m_rem = 0;
         else if (m_rem == 1) begin m_rem = 0; m_done = 1; dec = 1; end
         else m_rem--;
      end else if (m_done) begin
         if (!c) m_done = 0;
      end else if (m_blocked) begin
         if (m_stock > 0 || !c) m_blocked = 0;
      end else if (c) begin
         if (m_stock > 0) m_rem = T;
         else m_blocked = 1;
      end
      m_stock = m_stock - dec + add;
      if (m_stock > MAXS) m_stock = MAXS;
      m_prev = r;
   endtask

   task automatic check_all();
      check_eq("atuador", int'(atuador_vedacao), int'(m_rem > 0));
      check_eq("concluida", int'(vedacao_concluida), int'(m_done));
      check_eq("alarme", int'(alarme_rolha), int'(m_stock == 0 && !m_done));
      check_eq("baixa", int'(rolha_baixa), int'(m_stock != 0 && m_stock <= LIM));
      check_eq("estoque", int'(estoque_rolhas), m_stock);
   endtask

   // Called at a negedge: apply inputs, let one edge pass, check at the next negedge.
   task automatic tick(input bit c, input bit r);
      cmd_vedar = c;
      reposicao = r;
      @(posedge clk);
      model_edge(c, r);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      cmd_vedar = 1'b0;
      reposicao = 1'b0;
      reset = 1'b0;
   endtask

   task automatic seal();
      for (int i = 0; i < T + 1; i++) tick(1, 0);
      tick(0, 0);
   endtask

   initial begin
      bit c, r;
      model_reset();
      @(negedge clk);
      do_reset();
      check_eq("reset_estoque", int'(estoque_rolhas), 2);
      check_eq("reset_alarme", int'(alarme_rolha), 0);

      // 1: first seal
      for (int i = 0; i < T; i++) begin
         tick(1, 0);
         check_eq("p1_atuador", int'(atuador_vedacao), 1);
      end
      tick(1, 0);
      check_eq("p1_concluida", int'(vedacao_concluida), 1);
      check_eq("p1_estoque", int'(estoque_rolhas), 1);
      check_eq("p1_baixa", int'(rolha_baixa), 1);
      tick(0, 0);
      check_eq("p1_drop", int'(vedacao_concluida), 0);

      // 2: last cork, alarm held off during handshake
      for (int i = 0; i < T + 1; i++) tick(1, 0);
      check_eq("p2_estoque", int'(estoque_rolhas), 0);
      check_eq("p2_alarme_conc", int'(alarme_rolha), 0);
      tick(0, 0);
      check_eq("p2_alarme", int'(alarme_rolha), 1);

      // 3: no corks, refill, recovery
      tick(1, 0);
      check_eq("p3_alarme", int'(alarme_rolha), 1);
      check_eq("p3_atuador", int'(atuador_vedacao), 0);
      tick(1, 1);
      check_eq("p3_estoque", int'(estoque_rolhas), 5);
      check_eq("p3_alarme_off", int'(alarme_rolha), 0);
      tick(1, 0);
      check_eq("p3_idle", int'(atuador_vedacao), 0);
      tick(1, 0);
      check_eq("p3_vedando", int'(atuador_vedacao), 1);
      for (int i = 0; i < T; i++) tick(1, 0);
      check_eq("p3_conc", int'(vedacao_concluida), 1);
      check_eq("p3_estoque4", int'(estoque_rolhas), 4);
      tick(0, 0);

      // 4: saturation and level-held key
      tick(0, 1);
      check_eq("p4_sat", int'(estoque_rolhas), 6);
      for (int i = 0; i < 10; i++) tick(0, 1);
      tick(0, 0);
      check_eq("p4_hold", int'(estoque_rolhas), 6);

      // 5: refill on the completion edge
      seal(); seal(); seal();
      check_eq("p5_pre", int'(estoque_rolhas), 3);
      for (int i = 0; i < T; i++) tick(1, 0);
      tick(1, 1);
      check_eq("p5_simul", int'(estoque_rolhas), 6);
      tick(0, 0);

      // 6: abort, then reset mid-seal
      for (int i = 0; i < 3; i++) tick(1, 0);
      tick(0, 0);
      check_eq("p6_abort_atuador", int'(atuador_vedacao), 0);
      check_eq("p6_abort_estoque", int'(estoque_rolhas), 6);
      tick(1, 0);
      tick(1, 0);
      do_reset();
      check_eq("p6_reset_estoque", int'(estoque_rolhas), 2);
      check_eq("p6_reset_atuador", int'(atuador_vedacao), 0);

      // Randomized master and operator behaviour
      c = 0; r = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) c = ~c;
         if ($urandom_range(0, 5) == 0) r = ~r;
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
            c = 0; r = 0;
         end else begin
            tick(c, r);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
